// File: rtl/serial_link_pkg.sv
// Definitions shared by both ends of the single-wire serial link.
// These are the transmitter state encoding and the line levels the receiver expects.
package serial_link_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/serial_frame_tx_if.sv
// Parallel word handshake between a producer (master) and the frame transmitter (slave).
interface serial_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/bit_timer.sv
// Counts clocks within one serial bit period and flags the last cycle of each period.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    assign bit_end = (r_cnt == LAST_CNT);

    // Restart on the last cycle too, so the count never runs past CLKS_PER_BIT-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (clear || bit_end)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, DATA_W payload bits LSB first, stop bit.
// Each bit is held CLKS_PER_BIT clocks; the line output is registered and idles high.
module serial_frame_tx
    import serial_link_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    serial_frame_tx_if.slave   s_tx,
    output logic               tx_out,
    output logic               busy,
    output logic               done
);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic [BIT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic              r_tx_out, w_tx_out_nxt;
    logic              r_done, w_done_nxt;
    logic              w_bit_end, w_clear;

    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_clear),
        .bit_end (w_bit_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx_out  <= LINE_IDLE;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_tx_out  <= w_tx_out_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_tx_out_nxt  = LINE_IDLE;
        w_done_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                if (s_tx.tx_valid) begin
                    w_state_nxt = START;
                    w_shift_nxt = s_tx.tx_data;
                end
            end
            START: begin
                if (w_bit_end)
                    w_state_nxt = DATA;
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_shift_nxt   = r_shift >> 1;
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
        endcase

        if (w_state_nxt != r_state)
            w_bit_cnt_nxt = '0;

        // Line level is registered from the upcoming state, so it changes together with the state.
        case (w_state_nxt)
            IDLE:  w_tx_out_nxt = LINE_IDLE;
            START: w_tx_out_nxt = LINE_START;
            DATA:  w_tx_out_nxt = w_shift_nxt[0];
            STOP:  w_tx_out_nxt = LINE_STOP;
        endcase
    end

    assign w_clear       = (w_state_nxt != r_state) || (r_state == IDLE);
    assign s_tx.tx_ready = (r_state == IDLE);
    assign busy          = (r_state != IDLE);
    assign tx_out        = r_tx_out;
    assign done          = r_done;
endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: two instances (CLKS_PER_BIT 4 and 1), each checked every cycle
// against a queue of expected line levels built from the frame format.
module tb_serial_frame_tx;
    localparam int DATA_W = 8;
    localparam int NL     = 2;
    localparam int LIMIT  = 500;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] drv_data [NL];
    logic [NL-1:0]     drv_valid;
    logic [NL-1:0]     mon_out, mon_ready, mon_busy, mon_done;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NL; g++) begin : lane
        localparam int CPB = (g == 0) ? 4 : 1;

        serial_frame_tx_if #(.DATA_W(DATA_W)) bus ();
        logic tx_out, busy, done;

        assign bus.tx_data  = drv_data[g];
        assign bus.tx_valid = drv_valid[g];

        serial_frame_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
            .clk    (clk),
            .reset  (reset),
            .s_tx   (bus.slave),
            .tx_out (tx_out),
            .busy   (busy),
            .done   (done)
        );

        assign mon_out[g]   = tx_out;
        assign mon_ready[g] = bus.tx_ready;
        assign mon_busy[g]  = busy;
        assign mon_done[g]  = done;

        // Reference: one queue entry per clock of the line; empty queue means idle and ready.
        logic model_q [$];
        logic exp_done = 1'b0;

        always @(posedge clk or posedge reset) begin
            bit was_idle;
            if (reset) begin
                model_q.delete();
                exp_done = 1'b0;
            end else begin
                was_idle = (model_q.size() == 0);
                exp_done = 1'b0;
                if (!was_idle) begin
                    void'(model_q.pop_front());
                    exp_done = (model_q.size() == 0);
                end else if (drv_valid[g]) begin
                    for (int c = 0; c < CPB; c++) model_q.push_back(1'b0);
                    for (int b = 0; b < DATA_W; b++)
                        for (int c = 0; c < CPB; c++) model_q.push_back(drv_data[g][b]);
                    for (int c = 0; c < CPB; c++) model_q.push_back(1'b1);
                end
            end
        end

        always @(negedge clk) begin
            logic e_idle;
            e_idle = (model_q.size() == 0);
            check($sformatf("L%0d tx_out", g), tx_out, e_idle ? 1'b1 : model_q[0]);
            check($sformatf("L%0d tx_ready", g), bus.tx_ready, e_idle);
            check($sformatf("L%0d busy", g), busy, !e_idle);
            check($sformatf("L%0d done", g), done, exp_done);
        end
    end

    task automatic wait_ready(input int ln);
        int k = 0;
        while (!mon_ready[ln] && k < LIMIT) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("L%0d ready timeout", ln), k < LIMIT, 1);
    endtask

    task automatic send(input int ln, input logic [DATA_W-1:0] d);
        wait_ready(ln);
        drv_valid[ln] = 1'b1;
        drv_data[ln]  = d;
        @(negedge clk);
        drv_valid[ln] = 1'b0;
    endtask

    // Edge count includes the accepting edge itself.
    task automatic send_measure(input int ln, input logic [DATA_W-1:0] d, input int cpb);
        int n = 1;
        int busy_cnt = 0;
        send(ln, d);
        while (!mon_done[ln] && n < LIMIT) begin
            if (mon_busy[ln]) busy_cnt++;
            @(negedge clk);
            n++;
        end
        check($sformatf("L%0d done edge", ln), n, (DATA_W + 2) * cpb + 1);
        check($sformatf("L%0d busy cycles", ln), busy_cnt, (DATA_W + 2) * cpb);
    endtask

    initial begin
        int k;
        drv_valid = '0;
        for (int i = 0; i < NL; i++) drv_data[i] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        send_measure(0, 8'hA5, 4);

        // Back-to-back: valid held until the done cycle accepts the second word.
        wait_ready(0);
        drv_valid[0] = 1'b1;
        drv_data[0]  = 8'h00;
        @(negedge clk);
        drv_data[0] = 8'hFF;
        k = 0;
        while (!mon_done[0] && k < LIMIT) begin
            @(negedge clk);
            k++;
        end
        check("b2b done seen", k < LIMIT, 1);
        check("b2b idle gap", mon_out[0], 1);
        @(negedge clk);
        drv_valid[0] = 1'b0;
        check("b2b next start", mon_out[0], 0);
        check("b2b busy", mon_busy[0], 1);
        wait_ready(0);

        // Reset in the middle of payload bit 3.
        send(0, 8'h3C);
        repeat (17) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst tx_out", mon_out[0], 1);
        check("rst tx_ready", mon_ready[0], 1);
        check("rst busy", mon_busy[0], 0);
        check("rst done", mon_done[0], 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        send(0, 8'h3C);
        wait_ready(0);

        // Input activity during a frame must not disturb it.
        send(0, 8'h81);
        repeat (20) begin
            drv_valid[0] = 1'($urandom_range(0, 1));
            drv_data[0]  = 8'h55;
            @(negedge clk);
        end
        drv_valid[0] = 1'b0;
        wait_ready(0);
        repeat (3) @(negedge clk);

        send_measure(1, 8'h96, 1);
        repeat (3) @(negedge clk);

        repeat (600) begin
            for (int i = 0; i < NL; i++) begin
                drv_valid[i] = ($urandom_range(0, 2) == 0);
                drv_data[i]  = DATA_W'($urandom);
            end
            @(negedge clk);
        end
        drv_valid = '0;
        wait_ready(0);
        wait_ready(1);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Parallel-to-serial frame transmitter. It is the sending end of the single-wire serial link whose receiver is a D-flip-flop sampling chain.
- Accepts one DATA_W-bit word through a valid/ready handshake.
- Shifts the word out LSB first, framed by one start bit (0) and one stop bit (1).
- Holds each bit for CLKS_PER_BIT clocks.
- Sits between a parallel producer and the serial line.

Parameters:
DATA_W, 8, payload bits per frame (>=1)
CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1)

Ports:
clk  input  1  single system clock, all state updates on posedge
reset  input  1  asynchronous, active-high reset
tx_data  input  DATA_W  word to transmit, sampled only on accept
tx_valid  input  1  producer has a word on tx_data
tx_ready  output  1  block can accept a word this cycle
tx_out  output  1  serial line, idle high, registered
busy  output  1  high while a frame is in progress (START/DATA/STOP)
done  output  1  one-cycle pulse when a frame's stop bit completes

Behaviour:
- Reset (async, any time): state=IDLE, tx_out=1, tx_ready=1, busy=0, done=0, bit/clock counters=0, shift register=0. Takes effect immediately, without waiting for clk. A frame in flight is abandoned with no done pulse.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx_ready=1, busy=0, tx_out=1.
  - Accept = tx_valid && tx_ready at posedge. It latches tx_data into the shift register and moves to START at that same edge.
  - tx_ready=0 and busy=1 from the cycle after accept.
- START: tx_out=0 for exactly CLKS_PER_BIT cycles, then DATA.
- DATA:
  - tx_out = shift_reg[0]. Each bit is held CLKS_PER_BIT cycles, then the register shifts right.
  - After DATA_W bits, move to STOP.
- STOP: tx_out=1 for CLKS_PER_BIT cycles, then IDLE. done=1 for exactly the first IDLE cycle, and tx_ready=1 in that same cycle.
- Latency and timing:
  - tx_out first goes low the cycle after accept.
  - A frame occupies (DATA_W+2)*CLKS_PER_BIT cycles.
  - done is asserted (DATA_W+2)*CLKS_PER_BIT+1 edges after the accepting edge.
- Back-to-back: tx_valid held high during the done cycle is accepted in that cycle. The line then has exactly one idle-high cycle between stop bit and next start bit.
- tx_valid while tx_ready=0: ignored, no queueing. Changes on tx_data while busy do not affect the frame in progress.
- CLKS_PER_BIT=1: every bit is one cycle. No counter underflow or skipped bits.
- Clock counter width: $clog2(CLKS_PER_BIT), minimum 1 bit.
- Bit counter width: $clog2(DATA_W+1).
- Counters clear on every state change; no wrap-around beyond CLKS_PER_BIT-1.

Decomposition:
- Shared package serial_link_pkg holds:
  - state encoding constants IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - the line idle level (1), start level (0) and stop level (1), shared with the receiver.
- One natural sub-module: bit_timer.
  - Parameter CLKS_PER_BIT; inputs clk, reset, clear; output bit_end.
  - bit_end pulses on the last cycle of each bit period.
  - The FSM uses bit_end to advance states and the shift register.

Test Plan:
1. Reset then idle 10 cycles -> tx_out=1, tx_ready=1, busy=0, done=0 throughout.
2. DATA_W=8, CLKS_PER_BIT=4, send 0xA5 -> tx_out sequence, 4 cycles each: 0 | 1 0 1 0 0 1 0 1 | 1. busy high 40 cycles. done single pulse 41 edges after accept.
3. Send 0x00 then 0xFF back-to-back with tx_valid held -> second start bit follows exactly one idle-high cycle after first stop bit. Payloads are all-0 then all-1.
4. Assert reset during DATA bit 3 of 0x3C -> tx_out=1 and tx_ready=1 before next posedge, no done pulse. A new 0x3C sent after release transmits correctly.
5. Toggle tx_valid and change tx_data to 0x55 mid-frame of 0x81 -> 0x81 transmitted unaltered. 0x55 not sent unless tx_valid is held until tx_ready=1.
6. CLKS_PER_BIT=1, send 0x96 -> 10-cycle frame 0 0 1 1 0 1 0 0 1 1. done 11 edges after accept.
